// File: rtl/spi_frame_serializer_if.sv
// spi_frame_serializer_if
//   Parallel frame handshake into the SPI frame serializer.
//   frame_in    : parallel frame (upstream FIFO data_out)
//   frame_valid : frame_in holds a frame
//   frame_ready : serializer can accept a frame
//   Modports: master = frame source, slave = serializer.
interface spi_frame_serializer_if #(
    parameter int unsigned FRAME_BITS = 120
);
    logic [FRAME_BITS-1:0] frame_in;
    logic                  frame_valid;
    logic                  frame_ready;

    modport master (output frame_in, output frame_valid, input frame_ready);
    modport slave  (input frame_in, input frame_valid, output frame_ready);
endinterface

// File: rtl/spi_frame_serializer.sv
// spi_frame_serializer
//   Accepts one parallel frame per handshake and shifts it out MSB-first on
//   a generated SPI mode-0 link (sclk idles low, data changes on falling edge).
//   Optional feature: define SPI_SERIAL_PARITY_EN to append an even-parity bit
//   (XOR of the latched frame) after the LSB.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   frame_if : slave side of the frame handshake (frame_in/valid/ready)
//   sclk_out : SPI clock, CLK_DIV clk cycles per half period
//   cs_n_out : SPI chip select, active-low
//   sdo      : serial data, MSB-first
//   busy     : high from accept until return to idle
//   done     : one-cycle pulse when a frame completes
module spi_frame_serializer #(
    parameter int unsigned FRAME_BITS = 120,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned CS_SETUP   = 2,
    parameter int unsigned CS_HOLD    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    spi_frame_serializer_if.slave  frame_if,
    output logic                   sclk_out,
    output logic                   cs_n_out,
    output logic                   sdo,
    output logic                   busy,
    output logic                   done
);

`ifdef SPI_SERIAL_PARITY_EN
    localparam int unsigned TOTAL_BITS = FRAME_BITS + 1;
`else
    localparam int unsigned TOTAL_BITS = FRAME_BITS;
`endif
    // The first bit goes straight to sdo at accept, so the shift register
    // only holds the bits still to be sent.
    localparam int unsigned REM_BITS = TOTAL_BITS - 1;
    localparam int unsigned BIT_W    = $clog2(TOTAL_BITS + 1);
    localparam int unsigned DIV_W    = $clog2(CLK_DIV) + 1;
    localparam int unsigned PH_MAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PH_W     = $clog2(PH_MAX) + 1;

    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(TOTAL_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
    localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t              state;
    logic [REM_BITS-1:0] shreg;
    logic [BIT_W-1:0]    bit_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic [PH_W-1:0]     ph_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            shreg             <= '0;
            bit_cnt           <= '0;
            div_cnt           <= '0;
            ph_cnt            <= '0;
            frame_if.frame_ready <= 1'b1;
            sclk_out          <= 1'b0;
            cs_n_out          <= 1'b1;
            sdo               <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_if.frame_valid && frame_if.frame_ready) begin
`ifdef SPI_SERIAL_PARITY_EN
                        shreg <= {frame_if.frame_in[FRAME_BITS-2:0], ^frame_if.frame_in};
`else
                        shreg <= frame_if.frame_in[FRAME_BITS-2:0];
`endif
                        sdo                  <= frame_if.frame_in[FRAME_BITS-1];
                        cs_n_out             <= 1'b0;
                        busy                 <= 1'b1;
                        frame_if.frame_ready <= 1'b0;
                        bit_cnt              <= '0;
                        div_cnt              <= '0;
                        ph_cnt               <= '0;
                        state                <= SETUP;
                    end
                end
                SETUP: begin
                    if (ph_cnt == SETUP_LAST) begin
                        ph_cnt  <= '0;
                        div_cnt <= '0;
                        state   <= SHIFT;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (!sclk_out) begin
                            sclk_out <= 1'b1;
                        end else begin
                            // Falling edge: one bit finished.
                            sclk_out <= 1'b0;
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_LAST) begin
                                ph_cnt <= '0;
                                state  <= HOLD;
                            end else begin
                                sdo   <= shreg[REM_BITS-1];
                                shreg <= shreg << 1;
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (ph_cnt == HOLD_LAST) begin
                        cs_n_out             <= 1'b1;
                        busy                 <= 1'b0;
                        frame_if.frame_ready <= 1'b1;
                        done                 <= 1'b1;
                        sdo                  <= 1'b0;
                        state                <= IDLE;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_serializer.sv
module tb_spi_frame_serializer;
    localparam int unsigned N = 120;
`ifdef SPI_SERIAL_PARITY_EN
    localparam int unsigned D  = 1;
    localparam int unsigned PB = 1;
`else
    localparam int unsigned D  = 4;
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned S = 2;
    localparam int unsigned H = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    spi_frame_serializer_if #(.FRAME_BITS(N)) fif ();
    logic sclk_out, cs_n_out, sdo, busy, done;

    spi_frame_serializer #(
        .FRAME_BITS(N), .CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H)
    ) dut (
        .clk(clk), .rst(rst), .frame_if(fif),
        .sclk_out(sclk_out), .cs_n_out(cs_n_out), .sdo(sdo),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [N:0]  bits;
        int unsigned nbits;
        int unsigned cs_len;
        int          gap;     // required cs_n high cycles before this frame, -1 = don't care
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [N:0] act, input logic [N:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: the frame MSB-first, then the even-parity bit if enabled.
    function automatic exp_t model(input logic [N-1:0] d, input int gap);
        exp_t e;
        e.bits   = (PB == 1) ? {d, ^d} : {1'b0, d};
        e.nbits  = N + PB;
        e.cs_len = S + e.nbits * 2 * D + H;
        e.gap    = gap;
        return e;
    endfunction

    function automatic logic [N-1:0] rnd_frame();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[N-1:0];
    endfunction

    // Monitor: reconstructs frames from the SPI link and scores them.
    initial begin
        logic        pcs, psclk, cap_on;
        logic [N:0]  cap;
        int unsigned ncap, len, hi_len;
        exp_t        e;
        pcs = 1'b1; psclk = 1'b0; cap_on = 1'b0; cap = '0;
        ncap = 0; len = 0; hi_len = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (cap_on) begin
                    cap_on = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end
            end else if (cs_n_out) begin
                check("idle_link", {sclk_out, sdo}, 2'b00);
                if (!pcs && cap_on) begin
                    cap_on = 1'b0;
                    hi_len = 0;
                    check("done_at_end", done, 1);
                    check("ready_at_end", fif.frame_ready, 1);
                    check("busy_at_end", busy, 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_bits", cap, e.bits);
                        check("rise_count", ncap, e.nbits);
                        check("cs_low_len", len, e.cs_len);
                    end
                end else begin
                    check("done_idle", done, 0);
                end
                hi_len++;
            end else begin
                if (pcs) begin
                    cap_on = 1'b1; cap = '0; ncap = 0; len = 0;
                    if (exp_q.size() == 0) check("unexpected_start", 1, 0);
                    else if (exp_q[0].gap >= 0) check("cs_high_gap", hi_len, exp_q[0].gap);
                end
                check("done_mid", done, 0);
                len++;
                if (!psclk && sclk_out) begin
                    cap = {cap[N-1:0], sdo};
                    ncap++;
                end
            end
            pcs   = cs_n_out;
            psclk = sclk_out;
        end
    end

    task automatic send(input logic [N-1:0] d, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        fif.frame_in    = d;
        fif.frame_valid = 1'b1;
        while (!fif.frame_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!fif.frame_ready) begin
            check("accept_timeout", 0, 1);
            fif.frame_valid = 1'b0;
            return;
        end
        exp_q.push_back(model(d, gap));
        @(posedge clk);
        #1;
        fif.frame_valid = 1'b0;
        fif.frame_in    = ~d;   // must not disturb the frame in flight
        @(negedge clk);
        check("ready_after_accept", fif.frame_ready, 0);
        check("busy_after_accept", busy, 1);
        check("cs_after_accept", cs_n_out, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !cs_n_out) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) check("idle_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, fif.frame_ready, 1);
        check({tag, "_cs_n"}, cs_n_out, 1);
        check({tag, "_sclk"}, sclk_out, 0);
        check({tag, "_sdo"}, sdo, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        logic [N-1:0] d;
        fif.frame_valid = 1'b0;
        fif.frame_in    = '0;

        // Reset held, then released: outputs stay idle.
        repeat (5) @(negedge clk);
        check_reset_values("rst_hold");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("rst_release");

        // Directed frame.
        send({8'd1, 8'd2, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70,
              8'd100, 8'd120, 8'd130, 8'd140, 8'd150, 8'd55, 8'd200}, -1);
        wait_idle();

        // Back-to-back: second frame waits with valid high, accepted after done.
        send(rnd_frame(), -1);
        send({15{8'hAA}}, 1);
        wait_idle();

        // frame_valid while busy is ignored.
        d = rnd_frame();
        send(d, -1);
        repeat (40) @(negedge clk);
        fif.frame_in    = ~d;
        fif.frame_valid = 1'b1;
        check("ready_while_busy", fif.frame_ready, 0);
        @(negedge clk);
        fif.frame_valid = 1'b0;
        wait_idle();

        // Reset after 37 bits, then a complete frame.
        send(rnd_frame(), -1);
        repeat (S + 37 * 2 * D) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("rst_mid");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        send(rnd_frame(), -1);
        wait_idle();

        // Odd-popcount frame (parity bit 1 when enabled).
        send({{(N-1){1'b0}}, 1'b1}, -1);
        wait_idle();

        // Random frames, mixed back-to-back and idle gaps.
        for (int i = 0; i < 8; i++) begin
            send(rnd_frame(), -1);
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end
        wait_idle();
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
